ultrasonic_ranger: RTL and testbench

Initiator side of the ultrasonic sensor interface. It drives the sensor's trigger pin periodically, measures the returned echo pulse width in clk cycles, and publishes the result as echo_width to the inches conversion and height-latch logic. It sits between the sensor pins and the height-reading path, and runs free after reset.

---
 rtl/ranger_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/ultrasonic_ranger.sv | 166 ++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ranger_pkg.sv
// ranger_pkg
// Shared definitions for the ultrasonic ranging path.
//   state_t      : measurement FSM states
//   us_to_ticks  : microseconds -> clk cycles for a given clock frequency
//   ms_to_ticks  : milliseconds -> clk cycles for a given clock frequency
// The inches conversion uses the same helpers, so all tick counts stay
// derived from one clock frequency.
package ranger_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE
  } state_t;

  // Integer division first keeps the result exact for MHz-multiple clocks.
  function automatic logic [31:0] us_to_ticks(input logic [31:0] clk_hz,
                                              input logic [31:0] us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

  function automatic logic [31:0] ms_to_ticks(input logic [31:0] clk_hz,
                                              input logic [31:0] ms);
    return (clk_hz / 32'd1_000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both stages to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
// Initiator side of the ultrasonic sensor: fires the trigger pin once per
// measurement period, times the echo pulse in clk cycles and publishes it.
//   clk         : system clock
//   reset       : synchronous, active-high
//   echo        : raw sensor echo pin (asynchronous)
//   trig        : sensor trigger pin
//   echo_width  : last measured echo width in clk cycles, held between updates
//   width_valid : one-cycle strobe when echo_width updates
//   timeout     : one-cycle strobe alongside width_valid when no full echo
//                 was seen; echo_width then reads TIMEOUT_TICKS ("far")
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned PERIOD_MS   = 60,
  parameter int unsigned TIMEOUT_US  = 30_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        echo,
  output logic        trig,
  output logic [31:0] echo_width,
  output logic        width_valid,
  output logic        timeout
);

  localparam logic [31:0] TRIG_TICKS    = us_to_ticks(CLK_FREQ_HZ, TRIG_US);
  localparam logic [31:0] PERIOD_TICKS  = ms_to_ticks(CLK_FREQ_HZ, PERIOD_MS);
  localparam logic [31:0] TIMEOUT_TICKS = us_to_ticks(CLK_FREQ_HZ, TIMEOUT_US);

  logic echo_s;
  logic rise, fall;

  state_t      state_q, state_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] phase_cnt_q, phase_cnt_d;
  logic [31:0] width_cnt_q, width_cnt_d;
  logic [31:0] echo_width_q, echo_width_d;
  logic        first_flag_q, first_flag_d;
  logic        echo_q, echo_d;
  logic        trig_q, trig_d;
  logic        width_valid_q, width_valid_d;
  logic        timeout_q, timeout_d;
  logic        take_timeout;

  sync_2ff u_echo_sync (
    .clk  (clk),
    .reset(reset),
    .d    (echo),
    .q    (echo_s)
  );

  assign rise = echo_s & ~echo_q;
  assign fall = ~echo_s & echo_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    width_cnt_d   = width_cnt_q;
    first_flag_d  = first_flag_q;
    echo_width_d  = echo_width_q;
    width_valid_d = 1'b0;
    timeout_d     = 1'b0;
    take_timeout  = 1'b0;
    echo_d        = echo_s;
    period_cnt_d  = (period_cnt_q < PERIOD_TICKS) ? period_cnt_q + 32'd1
                                                  : period_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (first_flag_q || (period_cnt_q >= PERIOD_TICKS - 32'd1)) begin
          state_d      = S_TRIG;
          first_flag_d = 1'b0;
          phase_cnt_d  = '0;
        end
      end
      S_TRIG: begin
        if (phase_cnt_q == TRIG_TICKS - 32'd1) begin
          state_d     = S_WAIT_RISE;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 32'd1;
        end
      end
      S_WAIT_RISE: begin
        // Only a fresh edge starts a measurement; an echo already high
        // when the trigger ends never produces `rise` here.
        if (rise) begin
          state_d     = S_MEASURE;
          width_cnt_d = 32'd1;
        end else if (phase_cnt_q >= TIMEOUT_TICKS - 32'd1) begin
          take_timeout = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + 32'd1;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          echo_width_d  = width_cnt_q;
          width_valid_d = 1'b1;
          state_d       = S_IDLE;
        end else if (echo_s) begin
          if (width_cnt_q >= TIMEOUT_TICKS) begin
            take_timeout = 1'b1;
          end else begin
            width_cnt_d = width_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_timeout) begin
      echo_width_d  = TIMEOUT_TICKS;
      width_valid_d = 1'b1;
      timeout_d     = 1'b1;
      state_d       = S_IDLE;
    end

    // Period is measured from trigger start, so early completions still wait.
    if ((state_d == S_TRIG) && (state_q != S_TRIG)) begin
      period_cnt_d = '0;
    end

    // Registered pin, decoded from the next state so it tracks S_TRIG exactly.
    trig_d = (state_d == S_TRIG);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      period_cnt_q  <= '0;
      phase_cnt_q   <= '0;
      width_cnt_q   <= '0;
      echo_width_q  <= '0;
      first_flag_q  <= 1'b1;
      echo_q        <= 1'b0;
      trig_q        <= 1'b0;
      width_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      phase_cnt_q   <= phase_cnt_d;
      width_cnt_q   <= width_cnt_d;
      echo_width_q  <= echo_width_d;
      first_flag_q  <= first_flag_d;
      echo_q        <= echo_d;
      trig_q        <= trig_d;
      width_valid_q <= width_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign trig        = trig_q;
  assign echo_width  = echo_width_q;
  assign width_valid = width_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger
// Self-checking bench for ultrasonic_ranger with scaled timing
// (1 MHz clock, 1 ms period, 200 us timeout).
module tb_ultrasonic_ranger;

  localparam int CLK_HZ     = 1_000_000;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_MS  = 1;
  localparam int TIMEOUT_US = 200;

  localparam int TRIG_T   = CLK_HZ / 1_000_000 * TRIG_US;     // 10
  localparam int PERIOD_T = CLK_HZ / 1_000 * PERIOD_MS;       // 1000
  localparam int TO_T     = CLK_HZ / 1_000_000 * TIMEOUT_US;  // 200
  localparam int HOLD     = 1_000_000;                        // echo never falls

  typedef struct packed {
    int width;
    int to;
    int vidx;   // expected valid position after trigger end, -1 = unchecked
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        echo  = 1'b0;
  logic        trig;
  logic [31:0] echo_width;
  logic        width_valid;
  logic        timeout;

  int checks     = 0;
  int passes     = 0;
  int fails      = 0;
  int cyc        = 0;
  int last_rise  = 0;
  bit after_reset = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ultrasonic_ranger #(
    .CLK_FREQ_HZ(CLK_HZ),
    .TRIG_US    (TRIG_US),
    .PERIOD_MS  (PERIOD_MS),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .echo       (echo),
    .trig       (trig),
    .echo_width (echo_width),
    .width_valid(width_valid),
    .timeout    (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: what one measurement window should report, from the
  // echo pulse placed `delay` cycles after trigger end and lasting `len`.
  function automatic exp_t predict(input bit pre_high, input int delay, input int len);
    exp_t e;
    if (len == 0 || (pre_high && delay == 0)) begin
      // No new rising edge: the rise wait expires after TO_T cycles.
      e.width = TO_T; e.to = 1; e.vidx = TO_T;
    end else if (len >= TO_T + 2) begin
      e.width = TO_T; e.to = 1; e.vidx = -1;
    end else begin
      // Fall needs 2 sync cycles plus 1 detect/register cycle.
      e.width = len;  e.to = 0; e.vidx = delay + len + 3;
    end
    return e;
  endfunction

  // Waits for the next trigger, checks its spacing and its width, and returns
  // on the first cycle with trig low again.
  task automatic wait_trig();
    int  n    = 0;
    int  hi   = 1;
    bit  seen = 1'b0;
    for (int i = 1; i <= 2 * PERIOD_T && !seen; i++) begin
      @(negedge clk);
      n    = i;
      seen = (trig === 1'b1);
    end
    if (!seen)            check("trig_rise_wait", 32'd0, 32'd1);
    else if (after_reset) check("trig_after_reset", n, 1);
    else                  check("trig_period", cyc - last_rise, PERIOD_T);
    last_rise   = cyc;
    after_reset = 1'b0;
    for (int i = 0; i < 4 * TRIG_T; i++) begin
      @(negedge clk);
      if (trig !== 1'b1) break;
      hi++;
    end
    check("trig_width", hi, TRIG_T);
  endtask

  task automatic run_measure(input int delay, input int len, output int vcyc);
    exp_t        e;
    bit          pre_high;
    int          vidx  = -1;
    int          nvalid = 0;
    logic [31:0] got_w  = '0;
    logic        got_to = 1'b0;
    vcyc = 0;
    wait_trig();
    pre_high = (echo === 1'b1);
    e = predict(pre_high, delay, len);
    echo = (0 >= delay) && (0 < delay + len);
    for (int k = 1; k < PERIOD_T - 2 * TRIG_T; k++) begin
      @(negedge clk);
      if (width_valid === 1'b1) begin
        nvalid++;
        if (vidx < 0) begin
          vidx = k; got_w = echo_width; got_to = timeout; vcyc = cyc;
        end
      end
      echo = (k >= delay) && (k < delay + len);
      if (vidx >= 0 && k >= vidx + 2 && (len >= HOLD || k >= delay + len)) break;
    end
    check("echo_width", got_w, e.width);
    check("timeout_flag", {31'd0, got_to}, e.to);
    if (e.vidx >= 0) check("valid_latency", vidx, e.vidx);
    check("valid_pulses", nvalid, 1);
  endtask

  initial begin
    int vc;
    int prev_vc;
    int delay;
    int len;
    int kind;

    // Reset state
    reset = 1'b1;
    echo  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_trig", {31'd0, trig}, 0);
    check("rst_echo_width", echo_width, 0);
    check("rst_width_valid", {31'd0, width_valid}, 0);
    check("rst_timeout", {31'd0, timeout}, 0);
    reset       = 1'b0;
    after_reset = 1'b1;

    // Echo held low: rise-wait timeout
    run_measure(0, 0, vc);
    // Single normal echo
    run_measure(50, 174, vc);
    // Echo rises and never falls: measurement timeout
    run_measure(30, HOLD, vc);
    // Echo still high through the next trigger: no edge, timeout
    run_measure(0, HOLD, vc);
    echo = 1'b0;
    // Echo recovers and pulses normally
    run_measure(40, 100, vc);

    // Back-to-back 150-cycle echoes, one report per period
    prev_vc = 0;
    for (int i = 0; i < 20; i++) begin
      run_measure(20, 150, vc);
      if (i > 0) check("b2b_spacing", vc - prev_vc, PERIOD_T);
      prev_vc = vc;
    end

    // Randomized windows: no echo, overlong echo, or normal echo
    for (int i = 0; i < 15; i++) begin
      delay = $urandom_range(0, 150);
      kind  = $urandom_range(0, 9);
      if (kind == 0)      len = 0;
      else if (kind == 1) len = $urandom_range(TO_T + 2, 400);
      else                len = $urandom_range(1, TO_T - 2);
      run_measure(delay, len, vc);
    end

    // Reset 50 cycles into a measurement
    wait_trig();
    echo = 1'b1;
    repeat (53) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_trig", {31'd0, trig}, 0);
    check("midrst_echo_width", echo_width, 0);
    check("midrst_width_valid", {31'd0, width_valid}, 0);
    check("midrst_timeout", {31'd0, timeout}, 0);
    reset       = 1'b0;
    echo        = 1'b0;
    after_reset = 1'b1;
    run_measure(10, 5, vc);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
